// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: PC/next-PC hookup, instruction-memory request/grant
// channel and the decode-facing valid/ready queue head.
interface if_fetch_queue_if #(
    parameter int N = 32
);
    logic [N-1:0] pc_value;
    logic         pc_advance;
    logic         redirect;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;
    logic         out_valid;
    logic [N-1:0] out_instr;
    logic [N-1:0] out_pc;
    logic         out_ready;

    modport master (
        input  pc_value, redirect, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        output pc_advance, imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output pc_value, redirect, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        input  pc_advance, imem_req, imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch: one outstanding word fetch at a time, responses tagged
// with their PC and buffered in a small FIFO towards decode; redirect flushes.
module if_fetch_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_queue_if.master   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   req_pc_reg;
    logic [CW-1:0]  count_reg, count_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [N-1:0]   out_instr_reg, out_instr_next;
    logic [N-1:0]   out_pc_reg, out_pc_next;
    logic [2*N-1:0] mem [DEPTH];

    logic [N-1:0] fetch_addr;
    logic         req;
    logic         grant;
    logic         push;
    logic         pop;

    assign fetch_addr = bus.pc_value & ~N'(3);

    // Space is reserved at request time: a fetch only leaves when a slot is free.
    assign req   = !rst && (state_reg == S_REQ) && (count_reg < CW'(DEPTH)) && !bus.redirect;
    assign grant = req && bus.imem_gnt;
    assign push  = (state_reg == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop   = (count_reg != '0) && bus.out_ready && !bus.redirect;

    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        out_pc_next    = '0;
        out_instr_next = '0;
        if (bus.redirect) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
            count_next = count_reg + CW'(push) - CW'(pop);
            // New head is either already stored or is the word arriving now.
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                out_pc_next    = req_pc_reg;
                out_instr_next = bus.imem_rdata;
            end else begin
                {out_pc_next, out_instr_next} = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {req_pc_reg, bus.imem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_REQ;
            req_pc_reg    <= '0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
        end else begin
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            out_instr_reg <= out_instr_next;
            out_pc_reg    <= out_pc_next;
            case (state_reg)
                S_REQ: begin
                    if (grant) begin
                        state_reg  <= S_WAIT;
                        req_pc_reg <= fetch_addr;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid)   state_reg <= S_REQ;
                    else if (bus.redirect) state_reg <= S_DROP;
                end
                S_DROP: begin
                    // The stale response must still be absorbed before refetching.
                    if (bus.imem_rvalid) state_reg <= S_REQ;
                end
                default: state_reg <= S_REQ;
            endcase
        end
    end

    assign bus.imem_req   = req;
    assign bus.pc_advance = grant;
    assign bus.imem_addr  = rst ? '0 : fetch_addr;
    assign bus.out_valid  = (count_reg != '0);
    assign bus.out_instr  = out_instr_reg;
    assign bus.out_pc     = out_pc_reg;

    push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_reg == CW'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic checked
// against a transaction-level model (PC register, memory, expected queue).
module tb_if_fetch_queue;
    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.N(N)) bus();

    if_fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;
    int          m_wait;
    logic [31:0] m_rpc;
    bit          rv_force;
    int          n_adv;
    int          n_rv;

    logic        exp_req, exp_adv, exp_ov;
    logic [31:0] exp_addr;
    ent_t        exp_head;
    logic        obs_req, obs_adv, obs_ov;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    int errors = 0;
    int checks = 0;

    // One clock cycle: drive inputs, predict, sample, then advance the model.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit gnt,
                        input bit rdy, input int dly, input logic [31:0] data);
        bit rv;
        bit do_pop;
        @(negedge clk);
        rv = rv_force;
        if (m_out) begin
            m_wait--;
            if (m_wait <= 0) rv = 1'b1;
        end
        bus.pc_value    = m_pc;
        bus.redirect    = redir;
        bus.imem_gnt    = gnt;
        bus.out_ready   = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? data : $urandom;
        exp_req  = !m_out && (m_q.size() < DEPTH) && !redir;
        exp_adv  = exp_req && gnt;
        exp_addr = m_pc & 32'hFFFF_FFFC;
        exp_ov   = (m_q.size() > 0);
        exp_head = exp_ov ? m_q[0] : '0;
        #1;
        obs_req   = bus.imem_req;
        obs_adv   = bus.pc_advance;
        obs_addr  = bus.imem_addr;
        obs_ov    = bus.out_valid;
        obs_pc    = bus.out_pc;
        obs_instr = bus.out_instr;
        @(posedge clk);
        if (obs_adv) n_adv++;
        if (rv) n_rv++;
        do_pop = exp_ov && rdy && !redir;
        if (redir) m_q.delete();
        else if (do_pop) void'(m_q.pop_front());
        if (m_out && rv) begin
            if (!m_drop && !redir) m_q.push_back(ent_t'{pc: m_rpc, instr: data});
            m_out = 1'b0;
        end else if (m_out && redir) begin
            m_drop = 1'b1;
        end
        if (exp_adv) begin
            m_out  = 1'b1;
            m_drop = 1'b0;
            m_wait = dly;
            m_rpc  = exp_addr;
        end
        if (redir) m_pc = tgt;
        else if (exp_adv) m_pc = m_pc + 32'd4;
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && (m_out || m_q.size() != 0); i++)
            step(1'b0, 32'h0, 1'b0, 1'b1, 1, $urandom);
        checks++;
        if (m_out || m_q.size() != 0) begin
            errors++;
            $display("FAIL settle: outstanding=%0b queued=%0d want 0/0", m_out, m_q.size());
        end
    endtask

    task automatic test_reset();
        bus.pc_value = 32'h44; bus.redirect = 1'b0; bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
        checks++; if (bus.pc_advance !== 1'b0) begin errors++; $display("FAIL reset_adv: got %0b want 0", bus.pc_advance); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.out_instr); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.out_pc); end
        bus.imem_gnt = 1'b0;
        @(negedge clk) rst = 1'b0;
        m_q.delete(); m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_wait = 0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_stream();
        logic [31:0] tbl [3];
        int a0, r0, k, first_ov, idx;
        tbl[0] = 32'h20080005; tbl[1] = 32'h20090007; tbl[2] = 32'h01095020;
        a0 = n_adv; r0 = n_rv; k = 0; first_ov = -1;
        for (int c = 0; c < 12; c++) begin
            idx = n_rv - r0;
            step(1'b0, 32'h0, (n_adv - a0) < 3, 1'b1, 1, (idx < 3) ? tbl[idx] : 32'h0);
            if (obs_ov) begin
                if (first_ov < 0) first_ov = c;
                if (k < 3) begin
                    checks++;
                    if (obs_pc !== 32'(k * 4) || obs_instr !== tbl[k]) begin
                        errors++;
                        $display("FAIL stream_out%0d: got pc=%h instr=%h want pc=%h instr=%h",
                                 k, obs_pc, obs_instr, 32'(k * 4), tbl[k]);
                    end
                    $display("stream: pop pc=%h instr=%h", obs_pc, obs_instr);
                end
                k++;
            end
        end
        checks++; if (n_adv - a0 != 3) begin errors++; $display("FAIL stream_advances: got %0d want 3", n_adv - a0); end
        checks++; if (k != 3) begin errors++; $display("FAIL stream_outputs: got %0d want 3", k); end
        checks++; if (first_ov != 2) begin errors++; $display("FAIL stream_latency: got cycle %0d want 2", first_ov); end
    endtask

    task automatic test_backpressure();
        int a0;
        settle();
        a0 = n_adv;
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1, $urandom);
        checks++; if (n_adv - a0 != DEPTH) begin errors++; $display("FAIL bp_fills: got %0d want %0d", n_adv - a0, DEPTH); end
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %0b want 0", obs_req); end
        checks++; if (obs_ov !== 1'b1) begin errors++; $display("FAIL bp_valid_full: got %0b want 1", obs_ov); end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1, $urandom);
        a0 = n_adv;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, 1, $urandom);
        checks++; if (n_adv - a0 != 1) begin errors++; $display("FAIL bp_refill: got %0d requests want 1", n_adv - a0); end
        $display("backpressure: fills=%0d refill=%0d", DEPTH, n_adv - a0);
        settle();
    endtask

    task automatic test_grant_stall();
        int a0;
        settle();
        m_pc = 32'h40;
        a0 = n_adv;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1, $urandom);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h40 || obs_adv !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d: got req=%0b addr=%h adv=%0b want 1/00000040/0",
                         c, obs_req, obs_addr, obs_adv);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1, $urandom);
        checks++; if (obs_adv !== 1'b1) begin errors++; $display("FAIL stall_grant: got %0b want 1", obs_adv); end
        checks++; if (n_adv - a0 != 1) begin errors++; $display("FAIL stall_pulses: got %0d want 1", n_adv - a0); end
        $display("grant_stall: advance pulses=%0d", n_adv - a0);
        settle();
    endtask

    task automatic test_redirect_wait();
        settle();
        m_pc = 32'h10;
        step(1'b0, 32'h0, 1'b1, 1'b1, 3, $urandom);
        checks++; if (obs_adv !== 1'b1) begin errors++; $display("FAIL rw_grant: got %0b want 1", obs_adv); end
        step(1'b1, 32'h100, 1'b1, 1'b1, 3, $urandom);
        checks++; if (obs_req !== 1'b0 || obs_adv !== 1'b0) begin errors++; $display("FAIL rw_redirect: got req=%0b adv=%0b want 0/0", obs_req, obs_adv); end
        step(1'b0, 32'h0, 1'b0, 1'b1, 3, $urandom);
        step(1'b0, 32'h0, 1'b0, 1'b1, 3, 32'hDEADBEEF);
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %0b want 0", obs_req); end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1, $urandom);
        checks++;
        if (obs_ov !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            errors++;
            $display("FAIL rw_after: got valid=%0b req=%0b addr=%h want 0/1/00000100", obs_ov, obs_req, obs_addr);
        end
        $display("redirect_wait: next addr=%h", obs_addr);
        settle();
    endtask

    task automatic test_redirect_rvalid();
        settle();
        m_pc = 32'h20;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1, $urandom);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1, 32'h11111111);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2, $urandom);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2, $urandom);
        checks++; if (obs_ov !== 1'b1 || obs_instr !== 32'h11111111) begin errors++; $display("FAIL rr_head: got valid=%0b instr=%h want 1/11111111", obs_ov, obs_instr); end
        step(1'b1, 32'h200, 1'b0, 1'b1, 2, 32'h22222222);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1, $urandom);
        checks++;
        if (obs_ov !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            errors++;
            $display("FAIL rr_after: got valid=%0b req=%0b addr=%h want 0/1/00000200", obs_ov, obs_req, obs_addr);
        end
        $display("redirect_rvalid: next addr=%h", obs_addr);
        settle();
    endtask

    task automatic test_async_reset();
        settle();
        m_pc = 32'h30;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1, $urandom);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1, 32'h33333333);
        step(1'b0, 32'h0, 1'b1, 1'b0, 3, $urandom);
        @(negedge clk);
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.pc_advance !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL ar_outputs: got req=%0b adv=%0b valid=%0b instr=%h pc=%h want all 0",
                     bus.imem_req, bus.pc_advance, bus.out_valid, bus.out_instr, bus.out_pc);
        end
        @(negedge clk) rst = 1'b0;
        m_q.delete(); m_out = 1'b0; m_drop = 1'b0; m_wait = 0;
        rv_force = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1, 32'h55555555);
        rv_force = 1'b0;
        checks++; if (obs_req !== 1'b1) begin errors++; $display("FAIL ar_req: got %0b want 1", obs_req); end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1, $urandom);
        checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL ar_late_push: got valid=%0b want 0", obs_ov); end
        $display("async_reset: late response ignored");
        settle();
    endtask

    task automatic test_random();
        int cyc_err;
        settle();
        cyc_err = errors;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                 1'(($urandom_range(0, 1))), $urandom_range(1, 3), $urandom);
            checks++;
            if (obs_req !== exp_req || obs_adv !== exp_adv) begin
                errors++;
                $display("FAIL rnd_req c%0d: got req=%0b adv=%0b want %0b/%0b", c, obs_req, obs_adv, exp_req, exp_adv);
            end
            checks++;
            if (obs_addr !== exp_addr) begin
                errors++;
                $display("FAIL rnd_addr c%0d: got %h want %h", c, obs_addr, exp_addr);
            end
            checks++;
            if (obs_ov !== exp_ov) begin
                errors++;
                $display("FAIL rnd_valid c%0d: got %0b want %0b", c, obs_ov, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (obs_pc !== exp_head.pc || obs_instr !== exp_head.instr) begin
                    errors++;
                    $display("FAIL rnd_head c%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             c, obs_pc, obs_instr, exp_head.pc, exp_head.instr);
                end
            end
        end
        $display("random: 3000 cycles, %0d new errors", errors - cyc_err);
    endtask

    initial begin
        rv_force = 1'b0; n_adv = 0; n_rv = 0;
        m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_wait = 0; m_rpc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_grant_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register. Consumes the current PC value and issues word fetches to instruction memory over a request/grant handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO that feeds decode through a valid/ready handshake.
- Pulses `pc_advance` to the next-PC logic so the PC register loads PC+4 only when a fetch has actually been accepted.
- Handles control-flow redirects by flushing the queue and discarding the in-flight response.

Parameters:
- N, 32, address and instruction width.
- DEPTH, 2, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_value  in  N  current PC from the PC register.
- pc_advance  out  1  1-cycle pulse on each accepted fetch; next-PC logic selects PC+4 when high and holds PC when low.
- redirect  in  1  branch/jump taken this cycle; flush request.
- imem_req  out  1  fetch request.
- imem_addr  out  N  word-aligned fetch address: pc_value[N-1:2], 2'b00.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  N  instruction word.
- out_valid  out  1  queue head valid.
- out_instr  out  N  head instruction.
- out_pc  out  N  head PC.
- out_ready  in  1  decode consumes the head.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to REQ.
  - imem_req=0, pc_advance=0, out_valid=0.
  - Count, read pointer and write pointer all 0.
  - out_instr and out_pc are 0.
  - Reset asserted mid-transaction abandons any outstanding response silently; a late imem_rvalid after reset release while in REQ is ignored.
- Memory handshake: at most one outstanding fetch.
  - imem_req and imem_addr stay stable until imem_gnt.
  - Response arrives on imem_rvalid at least 1 cycle after the grant.
- FSM states:
  - REQ:
    - imem_req = (count < DEPTH) and not redirect.
    - On imem_req and imem_gnt: pulse pc_advance, latch the fetch address into req_pc, go to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid: push {req_pc, imem_rdata} into the queue, go to REQ.
    - On redirect without rvalid: go to DROP.
    - On redirect and rvalid in the same cycle: do not push, go to REQ.
  - DROP:
    - imem_req=0.
    - On imem_rvalid: discard the data, go to REQ.
    - Further redirects keep the FSM in DROP.
- Redirect in REQ:
  - imem_req is forced to 0 that cycle, so no grant can be accepted.
  - On the next cycle the request uses the new pc_value.
- Redirect flush: count=0 and pointers reset on the next edge, so out_valid=0 the following cycle. A pop requested in the redirect cycle is ignored.
- Space reservation:
  - A request is issued only when count < DEPTH at request time.
  - Pops can only increase space, so a push never overflows.
  - A push to a full queue is a design error; an assertion flags it.
- Queue:
  - Pop when out_valid and out_ready.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
  - Head outputs are registered from the storage array (array read at rd_ptr).
  - Empty: out_valid=0, and out_ready is ignored.
- Latency: an empty queue with 1-cycle memory response gives grant at cycle t, rvalid at t+1, out_valid at t+2.
- Throughput: one fetch per two cycles minimum (REQ → WAIT → REQ).
- pc_advance is high only in the grant cycle, never during reset, DROP or redirect.

Test Plan:
- Reset then streaming: rst pulse; pc_value follows 0x0, 0x4, 0x8; gnt always 1; rvalid 1 cycle after grant with rdata 0x20080005, 0x20090007, 0x01095020; out_ready=1 → three outputs in order with out_pc 0x0, 0x4, 0x8; pc_advance pulses exactly 3 times.
- Backpressure full: out_ready=0, DEPTH=2 → after 2 fills imem_req stays 0 and count=2; raise out_ready for one cycle → one pop, then exactly one new request is issued.
- Grant stall: imem_gnt=0 for 4 cycles with pc_value=0x40 → imem_req held high, imem_addr=0x40 stable, pc_advance=0 throughout; the grant in cycle 5 produces one pc_advance pulse.
- Redirect while waiting: grant at 0x10, redirect next cycle with pc_value=0x100, rvalid with 0xDEADBEEF 2 cycles later → data dropped, queue empty, next request addr 0x100.
- Redirect coinciding with rvalid: same-cycle redirect and rvalid → no push, FSM returns to REQ, next fetch from the new PC.
- Async reset mid-WAIT: assert rst between grant and rvalid → all outputs 0 immediately; the late rvalid after release pushes nothing.
